// File: rtl/vid_timing_pkg.sv
// Shared timing defaults, test-pattern encoding and colour-bar table for the
// raster timing generator.
package vid_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam logic [23:0] PIX_WHITE = 24'hFFFFFF;
    localparam logic [23:0] PIX_BLACK = 24'h000000;
    localparam logic [23:0] PIX_GREY  = 24'h808080;

    typedef enum logic [1:0] {
        PAT_BLACK = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_GRID  = 2'd2,
        PAT_GREY  = 2'd3
    } pattern_e;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Pixels are packed {B,G,R}.
    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = 24'hFFFFFF;
            3'd1:    c = 24'h00FFFF;
            3'd2:    c = 24'hFFFF00;
            3'd3:    c = 24'h00FF00;
            3'd4:    c = 24'hFF00FF;
            3'd5:    c = 24'h0000FF;
            3'd6:    c = 24'hFF0000;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vid_timing_gen_sync_delay.sv
// Fixed-depth shift register; reset loads every stage with rst_val so the
// output never shows a stale level after reset.
module sync_delay #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stages [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= rst_val;
            end
        end else begin
            stages[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/vid_timing_gen.sv
// Free-running raster timing generator with test-pattern fill and a
// latency-matched DAC sync/blank path for the returned pipeline pixels.
module vid_timing_gen
    import vid_timing_pkg::*;
#(
    parameter int   H_ACTIVE     = DEF_H_ACTIVE,
    parameter int   H_FP         = DEF_H_FP,
    parameter int   H_SYNC       = DEF_H_SYNC,
    parameter int   H_BP         = DEF_H_BP,
    parameter int   V_ACTIVE     = DEF_V_ACTIVE,
    parameter int   V_FP         = DEF_V_FP,
    parameter int   V_SYNC       = DEF_V_SYNC,
    parameter int   V_BP         = DEF_V_BP,
    parameter logic HS_POL       = 1'b0,
    parameter logic VS_POL       = 1'b0,
    parameter int   PIPE_LATENCY = 3
) (
    input  logic        vo_clk,
    input  logic        vo_reset,
    input  logic [1:0]  pattern_sel,
    output logic        out_vsync,
    output logic        out_req,
    output logic        out_eol,
    output logic        out_eof,
    output logic [23:0] out_pixel,
    input  logic        in_req,
    input  logic [23:0] in_pixel,
    output logic        dac_hsync,
    output logic        dac_vsync,
    output logic        dac_blank_,
    output logic [23:0] dac_pixel,
    output logic        sync_err
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
    localparam logic [11:0] H_EOL  = 12'(H_ACTIVE - 1);
    localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] BAR_W  = 12'(H_ACTIVE / 8);

    localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_ACT   = 11'(V_ACTIVE);
    localparam logic [10:0] V_EOF   = 11'(V_ACTIVE - 1);
    localparam logic [10:0] VS_BEG  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);

    if (PIPE_LATENCY < 1 || PIPE_LATENCY > 15) begin : g_bad_latency
        $error("vid_timing_gen: PIPE_LATENCY must be in 1..15");
    end

    logic [11:0] h_cnt;
    logic [10:0] v_cnt;
    logic        active;
    logic        hs_raw;
    logic        vs_raw;
    logic        frame_start;
    logic [2:0]  bar_idx;
    logic [23:0] pix_next;
    pattern_e    pat_q;
    pattern_e    pat_cur;
    logic        hs_q;
    logic        vs_q;
    logic [2:0]  dly_q;

    always_ff @(posedge vo_clk) begin
        if (vo_reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 11'd1;
        end else begin
            h_cnt <= h_cnt + 12'd1;
        end
    end

    assign active      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs_raw      = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign vs_raw      = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    assign frame_start = (h_cnt == '0) && (v_cnt == '0);
    assign bar_idx     = 3'(h_cnt / BAR_W);

    // The first pixel of a frame already uses the pattern being latched.
    assign pat_cur = frame_start ? pattern_e'(pattern_sel) : pat_q;

    always_comb begin
        pix_next = PIX_BLACK;
        if (active) begin
            case (pat_cur)
                PAT_BARS: pix_next = bar_colour(bar_idx);
                PAT_GRID: pix_next = (h_cnt[3:0] == 4'd0 || v_cnt[3:0] == 4'd0) ? PIX_WHITE : PIX_BLACK;
                PAT_GREY: pix_next = PIX_GREY;
                default:  pix_next = PIX_BLACK;
            endcase
        end
    end

    always_ff @(posedge vo_clk) begin
        if (vo_reset) begin
            out_req   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
            out_vsync <= 1'b0;
            out_pixel <= '0;
            hs_q      <= ~HS_POL;
            vs_q      <= ~VS_POL;
            pat_q     <= PAT_BLACK;
        end else begin
            out_req   <= active;
            out_eol   <= active && (h_cnt == H_EOL);
            out_eof   <= active && (h_cnt == H_EOL) && (v_cnt == V_EOF);
            out_vsync <= (h_cnt == '0) && (v_cnt == VS_BEG);
            out_pixel <= pix_next;
            hs_q      <= hs_raw ? HS_POL : ~HS_POL;
            vs_q      <= vs_raw ? VS_POL : ~VS_POL;
            if (frame_start) begin
                pat_q <= pattern_e'(pattern_sel);
            end
        end
    end

    // Sync/blank travel alongside the stream so they line up with in_req.
    sync_delay #(
        .WIDTH (3),
        .DEPTH (PIPE_LATENCY)
    ) u_sync_delay (
        .clk     (vo_clk),
        .reset   (vo_reset),
        .rst_val ({~HS_POL, ~VS_POL, 1'b0}),
        .d       ({hs_q, vs_q, out_req}),
        .q       (dly_q)
    );

    always_ff @(posedge vo_clk) begin
        if (vo_reset) begin
            dac_hsync  <= ~HS_POL;
            dac_vsync  <= ~VS_POL;
            dac_blank_ <= 1'b0;
            dac_pixel  <= '0;
            sync_err   <= 1'b0;
        end else begin
            dac_hsync  <= dly_q[2];
            dac_vsync  <= dly_q[1];
            dac_blank_ <= dly_q[0];
            dac_pixel  <= dly_q[0] ? in_pixel : '0;
            if (in_req != dly_q[0]) begin
                sync_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vid_timing_gen.sv
// Directed bench for vid_timing_gen on a reduced 48x27 raster with a
// behavioural loopback of the downstream pipeline.
module tb_vid_timing_gen;

    localparam int HA = 32, HF = 4, HS = 6, HB = 6;
    localparam int VA = 20, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;

    logic        vo_clk = 1'b0;
    logic        vo_reset = 1'b1;
    logic [1:0]  pattern_sel = 2'd0;
    logic        out_vsync, out_req, out_eol, out_eof;
    logic [23:0] out_pixel;
    logic        in_req;
    logic [23:0] in_pixel;
    logic        dac_hsync, dac_vsync, dac_blank_;
    logic [23:0] dac_pixel;
    logic        sync_err;

    vid_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_LATENCY(3)
    ) dut (
        .vo_clk(vo_clk), .vo_reset(vo_reset), .pattern_sel(pattern_sel),
        .out_vsync(out_vsync), .out_req(out_req), .out_eol(out_eol), .out_eof(out_eof),
        .out_pixel(out_pixel), .in_req(in_req), .in_pixel(in_pixel),
        .dac_hsync(dac_hsync), .dac_vsync(dac_vsync), .dac_blank_(dac_blank_),
        .dac_pixel(dac_pixel), .sync_err(sync_err)
    );

    always #5 vo_clk = ~vo_clk;

    // Downstream pipeline model: plain register delay, cleared by reset.
    int          lb = 3;
    logic [2:0]  req_pipe;
    logic [23:0] pix_pipe0, pix_pipe1, pix_pipe2;

    always @(posedge vo_clk) begin
        if (vo_reset) begin
            req_pipe  <= '0;
            pix_pipe0 <= '0;
            pix_pipe1 <= '0;
            pix_pipe2 <= '0;
        end else begin
            req_pipe  <= {req_pipe[1:0], out_req};
            pix_pipe0 <= out_pixel;
            pix_pipe1 <= pix_pipe0;
            pix_pipe2 <= pix_pipe1;
        end
    end

    assign in_req   = (lb == 3) ? req_pipe[2] : req_pipe[1];
    assign in_pixel = (lb == 3) ? pix_pipe2 : pix_pipe1;

    int n_chk = 0;
    int n_err = 0;
    int p = -1;
    int pat_tab [4] = '{0, 1, 2, 2};

    int bad_req, bad_eol, bad_eof, bad_vs, bad_pix, bad_blank, bad_hs, bad_vsd, bad_dpix, bad_err;
    int n_req, n_eol, n_eof, n_vs, n_nz, eof_pos, vs_pos;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit act(input int q);
        if (q < 0) return 1'b0;
        return ((q % HT) < HA) && (((q / HT) % VT) < VA);
    endfunction

    function automatic bit hs_on(input int q);
        if (q < 0) return 1'b0;
        return ((q % HT) >= HA + HF) && ((q % HT) < HA + HF + HS);
    endfunction

    function automatic bit vs_on(input int q);
        if (q < 0) return 1'b0;
        return (((q / HT) % VT) >= VA + VF) && (((q / HT) % VT) < VA + VF + VS);
    endfunction

    function automatic logic [23:0] bar(input int i);
        case (i)
            0: return 24'hFFFFFF;
            1: return 24'h00FFFF;
            2: return 24'hFFFF00;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'h0000FF;
            6: return 24'hFF0000;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [23:0] pix(input int q);
        int h, v, fr;
        if (!act(q)) return 24'h0;
        h  = q % HT;
        v  = (q / HT) % VT;
        fr = q / FR;
        if (fr > 3) fr = 3;
        case (pat_tab[fr])
            1: return bar(h / (HA / 8));
            2: return ((h % 16) == 0 || (v % 16) == 0) ? 24'hFFFFFF : 24'h000000;
            3: return 24'h808080;
            default: return 24'h000000;
        endcase
    endfunction

    task automatic clr_win();
        bad_req = 0; bad_eol = 0; bad_eof = 0; bad_vs = 0; bad_pix = 0;
        bad_blank = 0; bad_hs = 0; bad_vsd = 0; bad_dpix = 0; bad_err = 0;
        n_req = 0; n_eol = 0; n_eof = 0; n_vs = 0; n_nz = 0; eof_pos = -1; vs_pos = -1;
    endtask

    task automatic step();
        int  h, v;
        bit  e_req, e_eol;
        @(negedge vo_clk);
        p++;
        h     = p % HT;
        v     = (p / HT) % VT;
        e_req = act(p);
        e_eol = e_req && (h == HA - 1);
        if (out_req !== e_req) bad_req++;
        if (out_eol !== e_eol) bad_eol++;
        if (out_eof !== (e_eol && v == VA - 1)) bad_eof++;
        if (out_vsync !== (h == 0 && v == VA + VF)) bad_vs++;
        if (out_pixel !== pix(p)) bad_pix++;
        if (dac_blank_ !== act(p - 4)) bad_blank++;
        if (dac_hsync !== !hs_on(p - 4)) bad_hs++;
        if (dac_vsync !== !vs_on(p - 4)) bad_vsd++;
        if (lb == 3) begin
            if (dac_pixel !== pix(p - 4)) bad_dpix++;
            if (sync_err !== 1'b0) bad_err++;
        end
        if (out_req) n_req++;
        if (out_eol) n_eol++;
        if (out_eof) begin n_eof++; eof_pos = p; end
        if (out_vsync) begin n_vs++; if (vs_pos < 0) vs_pos = p; end
        if (out_pixel != 24'h0) n_nz++;
    endtask

    task automatic run_to(input int target);
        while (p < target) step();
    endtask

    task automatic check_window(input string tag);
        chk({tag, "_req_seq"},   bad_req,   0);
        chk({tag, "_eol_seq"},   bad_eol,   0);
        chk({tag, "_eof_seq"},   bad_eof,   0);
        chk({tag, "_vsync_seq"}, bad_vs,    0);
        chk({tag, "_pixel_seq"}, bad_pix,   0);
        chk({tag, "_blank_seq"}, bad_blank, 0);
        chk({tag, "_dac_hs"},    bad_hs,    0);
        chk({tag, "_dac_vs"},    bad_vsd,   0);
        chk({tag, "_dac_pix"},   bad_dpix,  0);
        chk({tag, "_sync_err"},  bad_err,   0);
        clr_win();
    endtask

    task automatic do_reset(input string tag);
        @(negedge vo_clk);
        vo_reset = 1'b1;
        @(negedge vo_clk);
        @(negedge vo_clk);
        chk({tag, "_rst_req"},   out_req,    0);
        chk({tag, "_rst_eol"},   out_eol,    0);
        chk({tag, "_rst_vsync"}, out_vsync,  0);
        chk({tag, "_rst_pix"},   out_pixel,  0);
        chk({tag, "_rst_hs"},    dac_hsync,  1);
        chk({tag, "_rst_vs"},    dac_vsync,  1);
        chk({tag, "_rst_blank"}, dac_blank_, 0);
        chk({tag, "_rst_dpix"},  dac_pixel,  0);
        chk({tag, "_rst_err"},   sync_err,   0);
        vo_reset = 1'b0;
        p = -1;
        clr_win();
    endtask

    initial begin
        clr_win();
        do_reset("init");

        // Frame 0: black pattern, full-frame statistics.
        step();
        chk("first_req", out_req, 1);
        run_to(FR - 1);
        chk("f0_req_count", n_req, HA * VA);
        chk("f0_eol_count", n_eol, VA);
        chk("f0_eof_count", n_eof, 1);
        chk("f0_eof_pos",   eof_pos, (VA - 1) * HT + HA - 1);
        chk("f0_vs_count",  n_vs, 1);
        chk("f0_vs_pos",    vs_pos, (VA + VF) * HT);
        chk("f0_nonzero",   n_nz, 0);
        check_window("f0");

        // Frame 1: colour bars; selecting grid mid-frame must not show yet.
        pattern_sel = 2'd1;
        run_to(FR + 5 * HT + 0);
        chk("bar_x0", out_pixel, 24'hFFFFFF);
        run_to(FR + 5 * HT + 4);
        chk("bar_x4", out_pixel, 24'h00FFFF);
        run_to(FR + 5 * HT + 12);
        chk("bar_x12", out_pixel, 24'h00FF00);
        run_to(FR + 5 * HT + 31);
        chk("bar_x31", out_pixel, 24'h000000);
        run_to(FR + 10 * HT - 1);
        pattern_sel = 2'd2;
        run_to(FR + 15 * HT + 4);
        chk("bar_after_sel", out_pixel, 24'h00FFFF);
        run_to(2 * FR - 1);
        chk("f1_eol_count", n_eol, VA);
        check_window("f1");

        // Frame 2: grid.
        run_to(2 * FR + 5);
        chk("grid_y0", out_pixel, 24'hFFFFFF);
        run_to(2 * FR + 3 * HT + 5);
        chk("grid_off", out_pixel, 24'h000000);
        run_to(2 * FR + 3 * HT + 16);
        chk("grid_x16", out_pixel, 24'hFFFFFF);
        run_to(2 * FR + 16 * HT + 7);
        chk("grid_y16", out_pixel, 24'hFFFFFF);
        run_to(3 * FR - 1);
        check_window("f2");

        // Reset mid-frame at h=30, v=12 of frame 3.
        run_to(3 * FR + 12 * HT + 30);
        check_window("f3");
        do_reset("mid");
        pat_tab[0] = 2;
        step();
        chk("mid_first_req", out_req, 1);
        chk("mid_first_pix", out_pixel, 24'hFFFFFF);
        run_to(1200);
        chk("mid_vs_count", n_vs, 1);
        chk("mid_vs_pos",   vs_pos, (VA + VF) * HT);
        check_window("mid");

        // Loopback one clock short: sync_err must trip on the first active clock.
        lb = 2;
        do_reset("lb2");
        run_to(2);
        chk("lb2_err_before", sync_err, 0);
        step();
        chk("lb2_err_set", sync_err, 1);
        run_to(3 * HT);
        chk("lb2_err_sticky", sync_err, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
